// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - SHA-256 message padder: packs 32-bit words into 512-bit blocks with 0x80 marker and 64-bit bit length.
module sha256_padder #(
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORDSIZE-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic [2:0]          in_nbytes,
    output logic                in_ready,
    output logic [511:0]        blk_data,
    output logic                blk_valid,
    input  logic                blk_ready,
    output logic                blk_first,
    output logic                blk_last
);
    typedef enum logic [1:0] {FILL, PAD, LEN, OUT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] buf_q [16];
    logic [60:0] cnt_q, cnt_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic        done_q, done_d;      // final input word has been taken
    logic        padded_q, padded_d;  // 0x80 marker has been placed
    logic        late_q, late_d;      // marker landed in word 14/15, length goes in next block
    logic        wr_en, clr;
    logic [31:0] wr_word;
    logic [31:0] keep_mask, pad_byte;
    logic [63:0] bit_len;

    assign bit_len   = {cnt_q, 3'b000};
    assign in_ready  = (state_q == FILL);
    assign blk_valid = (state_q == OUT);
    assign blk_first = blk_valid & first_q;
    assign blk_last  = blk_valid & last_q;

    always_comb begin
        blk_data = '0;
        for (int i = 0; i < 16; i++) begin
            blk_data[511-32*i -: 32] = buf_q[i];
        end
    end

    always_comb begin
        keep_mask = 32'hFFFF_FFFF;
        pad_byte  = 32'h0000_0000;
        case (in_nbytes)
            3'd0: begin keep_mask = 32'h0000_0000; pad_byte = 32'h8000_0000; end
            3'd1: begin keep_mask = 32'hFF00_0000; pad_byte = 32'h0080_0000; end
            3'd2: begin keep_mask = 32'hFFFF_0000; pad_byte = 32'h0000_8000; end
            3'd3: begin keep_mask = 32'hFFFF_FF00; pad_byte = 32'h0000_0080; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        last_d   = last_q;
        done_d   = done_q;
        padded_d = padded_q;
        late_d   = late_q;
        wr_en    = 1'b0;
        wr_word  = 32'h0;
        clr      = 1'b0;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_word = (in_data & keep_mask) | (in_last ? pad_byte : 32'h0);
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = cnt_q + 61'(in_nbytes);
                    if (in_last) begin
                        done_d = 1'b1;
                        if (in_nbytes < 3'd4) begin
                            padded_d = 1'b1;
                            late_d   = (idx_q >= 4'd14);
                            state_d  = LEN;
                        end else begin
                            state_d = PAD;
                        end
                    end
                    if (idx_q == 4'd15) begin
                        state_d = OUT;
                        last_d  = 1'b0;
                    end
                end
            end
            PAD: begin
                wr_en    = 1'b1;
                wr_word  = 32'h8000_0000;
                padded_d = 1'b1;
                late_d   = (idx_q >= 4'd14);
                idx_d    = idx_q + 4'd1;
                state_d  = LEN;
                if (idx_q == 4'd15) begin
                    state_d = OUT;
                    last_d  = 1'b0;
                end
            end
            LEN: begin
                // buffer is already zero, so only the two length words need writing
                idx_d = idx_q + 4'd1;
                if (!late_q && idx_q == 4'd14) begin
                    wr_en   = 1'b1;
                    wr_word = bit_len[63:32];
                end
                if (!late_q && idx_q == 4'd15) begin
                    wr_en   = 1'b1;
                    wr_word = bit_len[31:0];
                end
                if (idx_q == 4'd15) begin
                    state_d = OUT;
                    last_d  = !late_q;
                end
            end
            OUT: begin
                if (blk_ready) begin
                    clr     = 1'b1;
                    idx_d   = 4'd0;
                    first_d = 1'b0;
                    if (last_q) begin
                        state_d  = FILL;
                        cnt_d    = '0;
                        done_d   = 1'b0;
                        padded_d = 1'b0;
                        late_d   = 1'b0;
                        first_d  = 1'b1;
                    end else if (!done_q) begin
                        state_d = FILL;
                    end else if (!padded_q) begin
                        state_d = PAD;
                    end else begin
                        state_d = LEN;
                        late_d  = 1'b0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            idx_q    <= 4'd0;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            padded_q <= 1'b0;
            late_q   <= 1'b0;
            for (int i = 0; i < 16; i++) buf_q[i] <= 32'h0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            last_q   <= last_d;
            done_q   <= done_d;
            padded_q <= padded_d;
            late_q   <= late_d;
            if (clr) begin
                for (int i = 0; i < 16; i++) buf_q[i] <= 32'h0;
            end else if (wr_en) begin
                buf_q[idx_q] <= wr_word;
            end
        end
    end
endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter WORDSIZE, default 32, meaning input/output word width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port in_data  input  32  message word, big-endian; first byte in [31:24].
REQ-005 SHALL have port in_valid  input  1  in_data qualifier.
REQ-006 SHALL have port in_last  input  1  the current word is the final word of the message.
REQ-007 SHALL have port in_nbytes  input  3  number of valid bytes in the word: 4 when in_last=0; 0..4 when in_last=1 (0 only for an empty message).
REQ-008 SHALL have port in_ready  output  1  word accepted when in_valid&in_ready.
REQ-009 SHALL have port blk_data  output  512  padded block; word 0 in [511:480], word 15 in [31:0]; this is the M format loaded by the message schedule.
REQ-010 SHALL have port blk_valid  output  1  blk_data holds a complete block (acts as M_valid for the downstream stage).
REQ-011 SHALL have port blk_ready  input  1  downstream accepts the block when blk_valid&blk_ready.
REQ-012 SHALL have port blk_first  output  1  the block is the first block of a message; downstream reloads the IV.
REQ-013 SHALL have port blk_last  output  1  the block is the final block of a message; the digest is valid after it.

Function
REQ-014 SHALL implement FSM states FILL, PAD, LEN, OUT, plus a 4-bit word index idx and a 512-bit buffer.
REQ-015 SHALL drive in_ready = 1 only in FILL; each handshake writes one word to buffer[idx] and increments idx.
REQ-016 SHALL zero-mask bytes beyond in_nbytes; on in_last with n<4 bytes, SHALL place 0x80 at byte n of the same word.
REQ-017 SHALL keep a 61-bit byte counter; message bit length L = bytes<<3, which wraps modulo 2^64.
REQ-018 On in_last with n=4, SHALL go to PAD, which writes 0x80000000 at idx in one cycle.
REQ-019 After the 0x80 byte is placed, SHALL go to LEN.
REQ-020 In LEN, SHALL write zero words until idx=14, then write L[63:32] at word 14 and L[31:0] at word 15, one word per cycle.
REQ-021 If the 0x80 byte lands in word 14 or 15, SHALL zero-fill to word 15, emit the block with blk_last=0, then build a new block of words 0..13 = 0 with the length in words 14 and 15.
REQ-022 When word 15 is written in any state, SHALL go to OUT next cycle with blk_valid=1.
REQ-023 SHALL hold blk_data, blk_first and blk_last stable while blk_valid&!blk_ready.
REQ-024 On the block handshake, SHALL clear the buffer and set idx=0.
REQ-025 After the block handshake, SHALL go to FILL if the message is unfinished, LEN if the length is still pending, or FILL with the counter cleared after a final block.
REQ-026 SHALL set blk_first=1 only on the first block emitted after reset or after the previous final block.
REQ-027 SHALL set blk_last=1 only on the block carrying the length.
REQ-028 Latency SHALL be one cycle from the write of word 15 to blk_valid; minimum throughput is 17 cycles per block.
REQ-029 SHALL ignore in_data, in_valid, in_last and in_nbytes outside FILL.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, set state=FILL, idx=0, buffer=0, byte counter=0 and first-flag=1.
REQ-031 SHALL, after reset, drive blk_valid=0, blk_first=0, blk_last=0, blk_data=0 and in_ready=1.
REQ-032 SHALL let reset during any state, including OUT with a stalled block, discard the partial message; no block is emitted.

Verification
REQ-033 Bench SHALL check: "abc": 0x61626300, n=3, last -> one block; w0=0x61626380, w1..w14=0, w15=0x00000018, first=last=1.
REQ-034 Bench SHALL check: empty message (n=0, last) -> w0=0x80000000, all other words 0, first=last=1.
REQ-035 Bench SHALL check: 56-byte message -> two blocks; block 1 w14=0x80000000, w15=0, last=0; block 2 w0..w14=0, w15=0x000001C0, first=0, last=1.
REQ-036 Bench SHALL check: 64-byte message -> two blocks; block 2 w0=0x80000000, w15=0x00000200.
REQ-037 Bench SHALL check: blk_ready held low 5 cycles in OUT -> blk_data stable, in_ready=0, and exactly one handshake is counted.
REQ-038 Bench SHALL check: rst pulsed after 7 words, then "abc" is sent -> output matches REQ-033 exactly, with blk_first=1.
